// File: rtl/lw_sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lw_sha_pkg
// Description : Shared types and constants for the SHA DIN input buffer.
//               BUS_W   - bus word width (fixed at 32)
//               LVL_W   - width of the reported FIFO fill level
//               pack_state_e - packer FSM states
//               din_entry_t  - one stored FIFO entry (last flag + data)
// Revision    : 1.0 - initial release
// ============================================================================
package lw_sha_pkg;

    localparam int BUS_W      = 32;
    localparam int LVL_W      = 5;
    // Entries are sized for the widest core word; 32-bit cores use the low half.
    localparam int DIN_DATA_W = 64;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,   // no half word held
        HALF  = 1'b1    // high half of a 64-bit word is held
    } pack_state_e;

    typedef struct packed {
        logic                  last;
        logic [DIN_DATA_W-1:0] data;
    } din_entry_t;

endpackage
`default_nettype wire

// File: rtl/lw_sha_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lw_sha_sync_fifo
// Description : DEPTH-entry synchronous FIFO of din_entry_t with first-word
//               fall-through head, registered fill level, sync reset and flush.
// Ports       : clk_i, rst_i    - clock, synchronous active-high reset
//               flush_i         - clears contents (one priority below reset)
//               push_i/push_entry_i - write an entry (ignored when full)
//               pop_i           - remove the head entry (ignored when empty)
//               head_o          - entry at the read pointer
//               lvl_o           - number of stored entries, 0..DEPTH
//               full_o/empty_o  - level status
// Revision    : 1.0 - initial release
// ============================================================================
module lw_sha_sync_fifo
    import lw_sha_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  din_entry_t       push_entry_i,
    input  logic             pop_i,
    output din_entry_t       head_o,
    output logic [LVL_W-1:0] lvl_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] C_DEPTH_LVL = LVL_W'(DEPTH);

    din_entry_t       r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_q;
    logic [PTR_W-1:0] w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q;
    logic [PTR_W-1:0] w_rd_ptr_d;
    logic [LVL_W-1:0] r_lvl_q;
    logic [LVL_W-1:0] w_lvl_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_lvl_q == C_DEPTH_LVL);
    assign empty_o = (r_lvl_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign lvl_o   = r_lvl_q;
    assign head_o  = r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_lvl_d    = r_lvl_q;
        if (flush_i) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_lvl_d    = '0;
        end else begin
            // Power-of-two depth: pointers wrap by plain overflow.
            if (w_push) w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
            if (w_pop)  w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   w_lvl_d = r_lvl_q + LVL_W'(1);
                2'b01:   w_lvl_d = r_lvl_q - LVL_W'(1);
                default: w_lvl_d = r_lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_lvl_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_lvl_q    <= w_lvl_d;
        end
    end

    // Storage needs no reset: it is only observed through the level.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i && !rst_i) begin
            r_mem_q[r_wr_ptr_q] <= push_entry_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lw_sha_din_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lw_sha_din_fifo
// Description : SHA DIN input buffer. Accepts 32-bit bus words, packs word
//               pairs into 64-bit core words in 64-bit modes, buffers them in
//               a small FIFO and hands them to the core via valid/ready.
// Ports       : clk_i, rst_i    - clock, synchronous active-high reset
//               s64_i           - 1 = pack two bus words per entry
//               flush_i         - abort, clears all contents
//               wr_valid_i/wr_data_i/wr_last_i/wr_ready_o - bus write side
//               data_o/last_o/valid_o/ready_i - core read side
//               lvl_o           - stored entries (STS.fifoinlvl)
//               ovf_o           - one-cycle pulse on dropped data (STS.derr)
// Revision    : 1.0 - initial release
// ============================================================================
module lw_sha_din_fifo
    import lw_sha_pkg::LVL_W;
#(
    parameter int BUS_W  = 32,
    parameter int WORD_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s64_i,
    input  logic              flush_i,
    input  logic              wr_valid_i,
    input  logic [BUS_W-1:0]  wr_data_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [WORD_W-1:0] data_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [LVL_W-1:0]  lvl_o,
    output logic              ovf_o
);

    import lw_sha_pkg::*;

    pack_state_e      r_state_q;
    pack_state_e      w_state_d;
    logic [BUS_W-1:0] r_hold_q;
    logic [BUS_W-1:0] w_hold_d;
    logic             r_ovf_q;
    logic             w_ovf_d;

    logic             w_pack64;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    din_entry_t       w_push_entry;
    din_entry_t       w_head;
    logic             w_full;
    logic             w_empty;

    // Packing only applies when the core word can hold two bus words.
    assign w_pack64 = s64_i && (WORD_W == 64);

    // A non-final high half only lands in the hold register, so it can be
    // taken even when the FIFO is full.
    assign wr_ready_o = !w_full || (w_pack64 && (r_state_q == EMPTY) && !wr_last_i);
    assign w_accept   = wr_valid_i && wr_ready_o;

    assign valid_o = !w_empty;
    assign w_pop   = valid_o && ready_i;
    assign data_o  = valid_o ? w_head.data[WORD_W-1:0] : '0;
    assign last_o  = valid_o && w_head.last;
    assign ovf_o   = r_ovf_q;

    always_comb begin
        w_state_d    = r_state_q;
        w_hold_d     = r_hold_q;
        w_ovf_d      = 1'b0;
        w_push       = 1'b0;
        w_push_entry = '0;

        if (wr_valid_i && !wr_ready_o) begin
            w_ovf_d = 1'b1;
        end

        // Leaving 64-bit mode mid-pair loses the held half.
        if ((r_state_q == HALF) && !w_pack64) begin
            w_state_d = EMPTY;
            w_ovf_d   = 1'b1;
        end

        if (w_accept) begin
            if (!w_pack64) begin
                w_push            = 1'b1;
                w_push_entry.data = DIN_DATA_W'(wr_data_i);
                w_push_entry.last = wr_last_i;
            end else if (r_state_q == HALF) begin
                w_push            = 1'b1;
                w_push_entry.data = {r_hold_q, wr_data_i};
                w_push_entry.last = wr_last_i;
                w_state_d         = EMPTY;
            end else if (wr_last_i) begin
                w_push            = 1'b1;
                w_push_entry.data = {wr_data_i, {BUS_W{1'b0}}};
                w_push_entry.last = 1'b1;
            end else begin
                w_hold_d  = wr_data_i;
                w_state_d = HALF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state_q <= EMPTY;
            r_hold_q  <= '0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_hold_q  <= w_hold_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    lw_sha_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .lvl_o        (lvl_o),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

endmodule
`default_nettype wire

// File: doc/lw_sha_din_fifo.md
Name: lw_sha_din_fifo

Overview:
Input data buffer between the SHA register interface (DIN write path) and the hash core's message input. Accepts bus-width words and packs pairs of 32-bit words into 64-bit core words when the core is in a 64-bit mode. Stores them in a small FIFO and presents them to the core with a valid/ready handshake. Reports fill level for STS.fifoinlvl, a per-word last flag, and a one-cycle overflow pulse that feeds STS.derr.

Parameters:
BUS_W, 32, bus word width in bits; fixed at 32.
WORD_W, 64, core word width in bits; 32 or 64.
DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous, active-high reset.
s64_i  in  1  1 = pack two bus words per entry (64-bit opcodes); 0 = one bus word per entry.
flush_i  in  1  abort/soft reset; clears all contents.
wr_valid_i  in  1  bus word present.
wr_data_i  in  BUS_W  bus word.
wr_last_i  in  1  final word of message.
wr_ready_o  out  1  word will be accepted this cycle.
data_o  out  WORD_W  head entry data to core.
last_o  out  1  head entry is final word.
valid_o  out  1  head entry present.
ready_i  in  1  core consumes head when valid_o.
lvl_o  out  5  number of stored entries, 0..DEPTH.
ovf_o  out  1  one-cycle pulse: write attempted while not ready; word dropped.

Behaviour:
- Reset and flush values:
  - rst_i (sync, priority over all) clears storage pointers, level and packer state.
  - valid_o=0, last_o=0, data_o=0, lvl_o=0, ovf_o=0, wr_ready_o=1.
  - flush_i has the same effect one priority below rst_i and overrides any same-cycle push, pop or overflow.
- Packer FSM, states EMPTY and HALF:
  - EMPTY, s64_i=1, accepted word, wr_last_i=0: word goes to the high half of the hold register; go to HALF. No push.
  - EMPTY, s64_i=1, accepted word, wr_last_i=1: push entry {word, 32'h0} with last=1; stay EMPTY.
  - HALF, accepted word: push {held_high, word} with last=wr_last_i; go to EMPTY.
  - s64_i=0 or WORD_W=32: every accepted word pushes an entry, zero-extended in the low bits, with last=wr_last_i; state stays EMPTY.
  - s64_i falling while in HALF: the held half is discarded, ovf_o pulses, state goes to EMPTY.
- Acceptance:
  - wr_ready_o = !full OR (s64_i AND state==EMPTY AND !wr_last_i). It is combinational and has no dependence on ready_i.
  - A word is accepted when wr_valid_i AND wr_ready_o.
  - wr_valid_i AND !wr_ready_o: the word is dropped, ovf_o=1 for the next cycle, no state change.
- Latency:
  - An entry pushed at edge N shows on valid_o/data_o/last_o after edge N (first-word fall-through, read directly from storage).
  - Pop happens at the edge where valid_o AND ready_i.
- Level:
  - lvl_o is registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Push while full is impossible by construction.
  - Pop while empty is ignored; data_o is don't-care when valid_o=0.
- Pointers are log2(DEPTH) bits and wrap naturally. full = (lvl_o==DEPTH); empty = (lvl_o==0).
- Ordering: strict FIFO. The high half of each 64-bit entry is always the earlier bus word.

Decomposition:
- lw_sha_pkg holds:
  - BUS_W constant.
  - packer state enum {EMPTY, HALF}.
  - din_entry_t struct {last, data[WORD_W-1:0]}.
  - LVL_W=5.
- Sub-module lw_sha_sync_fifo (generic DEPTH x din_entry_t, push/pop/level/full/empty, sync reset and flush).
- The packer FSM and overflow logic stay in the top module.

Test Plan:
1. s64_i=0, ready_i=0; write 0x1, 0x2, 0x3 -> lvl_o=3, wr_ready_o=1. Then ready_i=1 -> data_o 0x1, 0x2, 0x3 on consecutive cycles, lvl_o back to 0.
2. s64_i=1; write 0x11111111 then 0x22222222 -> lvl_o stays 0 after the first word. One cycle after the second word: valid_o=1, data_o=0x1111111122222222, last_o=0.
3. s64_i=1; single word 0xAAAA5555 with wr_last_i=1 -> data_o=0xAAAA555500000000, last_o=1, lvl_o=1.
4. s64_i=0, DEPTH=4, ready_i=0; write 5 words -> wr_ready_o=0 after the 4th, 5th word dropped, ovf_o high exactly one cycle, lvl_o=4. Drain gives words 1-4 only.
5. s64_i=1, lvl_o=2; pop and complete a pair in the same cycle -> lvl_o stays 2. Then flush_i while in HALF -> lvl_o=0, valid_o=0; the next word is treated as a high half.
6. rst_i asserted mid-stream with lvl_o=3 and state HALF -> next cycle all outputs at reset values. A subsequent pair packs correctly.
